bar_width_capture: RTL

Upstream writer for the barcode sample RAM. It samples the raw optical scanner line and measures the width of every bar and space in sample ticks. Each width is written as one byte, in order, into the 1024 x 8 RAM through that RAM's MEMW/CS/Address/data port. The downstream Code 39 decoder later reads the stored widths back from the same RAM.

---
 rtl/bar_width_capture_if.sv | 13 +
 rtl/bar_width_capture.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bar_width_capture_if.sv
// RAM-side port bundle used by the bar width writer.
// The 8-bit data bus is a plain inout on the writer itself.
interface bar_width_capture_if;
  localparam int unsigned AW = 10;

  logic          memw;
  logic          memr;
  logic          cs;
  logic [AW-1:0] address;

  modport master (output memw, memr, cs, address);
  modport slave  (input  memw, memr, cs, address);
endinterface

// File: rtl/bar_width_capture.sv
// Measures black/white element widths on the scanner line in sample ticks and
// writes them, one byte each and in order, into the barcode sample RAM.
// QUIET is compared against the 8-bit run counter, so it must not exceed 255.
module bar_width_capture #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned QUIET    = 200,
  parameter int unsigned MAX_ELEM = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        scan_i,
  input  logic                        start_i,
  bar_width_capture_if.master         ram,
  inout  wire  [7:0]                  data_io,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [10:0]                 count_o,
  output logic                        overflow_o
);

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 11;
  localparam int unsigned RW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick_c;
  logic          level;
  logic          cur_q, cur_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic [RW-1:0] width_q, width_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, count_inc;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          memw_q, memw_d;

  assign level     = sync_q[1];
  assign tick_c    = (tick_cnt_q == TW'(DIV - 1));
  assign run_inc   = (run_q == {RW{1'b1}}) ? run_q : run_q + RW'(1);
  assign count_inc = count_q + CW'(1);

  // Two-flop synchronizer and free-running sample tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b00;
      tick_cnt_q <= '0;
    end else begin
      sync_q     <= {sync_q[0], scan_i};
      tick_cnt_q <= tick_c ? '0 : tick_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_q      <= 1'b0;
      run_q      <= '0;
      width_q    <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      memw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      run_q      <= run_d;
      width_q    <= width_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      memw_q     <= memw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    run_d      = run_q;
    width_d    = width_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    busy_d     = busy_q;
    memw_d     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d    = S_ARM;
          count_d    = '0;
          overflow_d = 1'b0;
          done_d     = 1'b0;
          wr_ptr_d   = '0;
          busy_d     = 1'b1;
        end
      end

      // Leading white is skipped; measurement starts on the first black tick
      S_ARM: begin
        if (tick_c && level) begin
          state_d = S_MEASURE;
          cur_d   = 1'b1;
          run_d   = RW'(1);
        end
      end

      S_MEASURE: begin
        if (tick_c) begin
          if (level == cur_q) begin
            run_d = run_inc;
            if (!cur_q && (count_q != '0) && (run_inc == RW'(QUIET))) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            width_d = run_q;
            run_d   = RW'(1);
            cur_d   = level;
            memw_d  = 1'b1;
            state_d = S_WRITE;
          end
        end
      end

      // Pointer holds on the final write so the address never wraps
      S_WRITE: begin
        count_d = count_inc;
        if (count_inc == CW'(MAX_ELEM)) begin
          overflow_d = 1'b1;
          state_d    = S_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          state_d  = S_MEASURE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ram.memw    = memw_q;
  assign ram.cs      = memw_q;
  assign ram.memr    = 1'b0;
  assign ram.address = wr_ptr_q;
  assign data_io     = memw_q ? width_q : 8'bzzzz_zzzz;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
